// File: rtl/result_tx_pkg.sv
// Shared types and ASCII constants for the result UART transmitter.
package result_tx_pkg;

    typedef enum logic [1:0] {IDLE, CONVERT, BUILD, SEND} state_t;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_O     = 8'h4F;
    localparam logic [7:0] ASCII_V     = 8'h56;
    localparam logic [7:0] ASCII_F     = 8'h46;

    localparam int unsigned MAX_LINE = 6;

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one shift per cycle, RESULT_W cycles after start.
// done is high during the final shift cycle; bcd is valid from the next cycle.
module bin2bcd_seq #(
    parameter int unsigned RESULT_W = 9,
    parameter int unsigned DIGITS   = 3
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic [RESULT_W-1:0]   bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned CntW = $clog2(RESULT_W + 1);

    logic [RESULT_W-1:0] sh_q, sh_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d, adj;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                run_q, run_d;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        sh_d  = sh_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            sh_d  = bin;
            bcd_d = '0;
            cnt_d = CntW'(RESULT_W);
            run_d = 1'b1;
        end else if (run_q) begin
            {bcd_d, sh_d} = {adj, sh_q} << 1;
            cnt_d         = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sh_q  <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            sh_q  <= sh_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign done = run_q && (cnt_q == CntW'(1));
    assign bcd  = bcd_q;

endmodule

// File: rtl/result_uart_tx.sv
// Captures an ALU result and streams it as an ASCII line ("-123\r\n" / "OVF\r\n").
// Define RESULT_UART_TX_PENDING_EN to queue one result strobed while busy.
module result_uart_tx
    import result_tx_pkg::*;
#(
    parameter int unsigned RESULT_W = 9,
    parameter int unsigned DIGITS   = 3
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [RESULT_W-1:0] result,
    input  logic                sign,
    input  logic                o_flag,
    input  logic                result_ready,
    input  logic                txready,
    output logic [7:0]          txdata,
    output logic                txclk,
    output logic                busy
);

    state_t              state_q, state_d;
    logic                sign_q, sign_d;
    logic                oflag_q, oflag_d;
    logic [7:0]          line_q [MAX_LINE];
    logic [7:0]          line_d [MAX_LINE];
    logic [7:0]          build_line [MAX_LINE];
    logic [2:0]          build_len;
    logic [2:0]          len_q, len_d;
    logic [2:0]          idx_q, idx_d;
    logic [7:0]          txdata_q, txdata_d;

    logic                cap_valid;
    logic [RESULT_W-1:0] cap_result;
    logic                cap_sign;
    logic                cap_oflag;
    logic                conv_done;
    logic [4*DIGITS-1:0] bcd;

`ifdef RESULT_UART_TX_PENDING_EN
    logic                pend_valid_q, pend_valid_d;
    logic [RESULT_W-1:0] pend_result_q;
    logic                pend_sign_q, pend_oflag_q;

    // A queued entry takes priority over a same-cycle strobe, which then refills the slot.
    always_comb begin
        cap_valid    = (state_q == IDLE) && (pend_valid_q || result_ready);
        cap_result   = pend_valid_q ? pend_result_q : result;
        cap_sign     = pend_valid_q ? pend_sign_q   : sign;
        cap_oflag    = pend_valid_q ? pend_oflag_q  : o_flag;
        pend_valid_d = pend_valid_q;
        if (result_ready && busy) begin
            pend_valid_d = 1'b1;
        end else if (state_q == IDLE) begin
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pend_valid_q  <= 1'b0;
            pend_result_q <= '0;
            pend_sign_q   <= 1'b0;
            pend_oflag_q  <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            if (result_ready && busy) begin
                pend_result_q <= result;
                pend_sign_q   <= sign;
                pend_oflag_q  <= o_flag;
            end
        end
    end

    assign busy = (state_q != IDLE) || pend_valid_q;
`else
    always_comb begin
        cap_valid  = (state_q == IDLE) && result_ready;
        cap_result = result;
        cap_sign   = sign;
        cap_oflag  = o_flag;
    end

    assign busy = (state_q != IDLE);
`endif

    bin2bcd_seq #(
        .RESULT_W (RESULT_W),
        .DIGITS   (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .nrst  (nrst),
        .start (cap_valid && !cap_oflag),
        .bin   (cap_result),
        .done  (conv_done),
        .bcd   (bcd)
    );

    // Line formatter: optional minus, zero-suppressed digits, CR LF.
    always_comb begin
        logic [2:0] pos;
        logic       started;
        logic [3:0] digit;
        for (int k = 0; k < int'(MAX_LINE); k++) begin
            build_line[k] = 8'h00;
        end
        pos     = 3'd0;
        started = 1'b0;
        digit   = 4'd0;
        if (oflag_q) begin
            build_line[0] = ASCII_O;
            build_line[1] = ASCII_V;
            build_line[2] = ASCII_F;
            build_line[3] = ASCII_CR;
            build_line[4] = ASCII_LF;
            build_len     = 3'd5;
        end else begin
            if (sign_q && (bcd != '0)) begin
                build_line[pos] = ASCII_MINUS;
                pos             = pos + 3'd1;
            end
            for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
                digit = bcd[4*i +: 4];
                if (started || (digit != 4'd0) || (i == 0)) begin
                    started         = 1'b1;
                    build_line[pos] = ASCII_0 + {4'h0, digit};
                    pos             = pos + 3'd1;
                end
            end
            build_line[pos] = ASCII_CR;
            pos             = pos + 3'd1;
            build_line[pos] = ASCII_LF;
            build_len       = pos + 3'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        oflag_d  = oflag_q;
        line_d   = line_q;
        len_d    = len_q;
        idx_d    = idx_q;
        txdata_d = txdata_q;
        unique case (state_q)
            IDLE: begin
                if (cap_valid) begin
                    sign_d  = cap_sign;
                    oflag_d = cap_oflag;
                    state_d = cap_oflag ? BUILD : CONVERT;
                end
            end
            CONVERT: begin
                if (conv_done) begin
                    state_d = BUILD;
                end
            end
            BUILD: begin
                line_d   = build_line;
                len_d    = build_len;
                idx_d    = 3'd0;
                txdata_d = build_line[0];
                state_d  = SEND;
            end
            SEND: begin
                if (txready) begin
                    if (idx_q == len_q - 3'd1) begin
                        idx_d    = 3'd0;
                        txdata_d = 8'h00;
                        state_d  = IDLE;
                    end else begin
                        idx_d    = idx_q + 3'd1;
                        txdata_d = line_q[idx_q + 3'd1];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            oflag_q  <= 1'b0;
            line_q   <= '{default: 8'h00};
            len_q    <= 3'd0;
            idx_q    <= 3'd0;
            txdata_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            oflag_q  <= oflag_d;
            line_q   <= line_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            txdata_q <= txdata_d;
        end
    end

    assign txdata = txdata_q;
    assign txclk  = (state_q == SEND) && txready;

endmodule

// File: tb/tb_result_uart_tx.sv
// Self-checking bench for result_uart_tx: vector table, hand-written reset/overlap
// sequences and randomized results checked against a string-formatting model.
module tb_result_uart_tx;

    localparam int RW     = 9;
    localparam int MaxCyc = 400;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic [RW-1:0] result = '0;
    logic          sign = 1'b0;
    logic          o_flag = 1'b0;
    logic          result_ready = 1'b0;
    logic          txready = 1'b0;
    logic [7:0]    txdata;
    logic          txclk;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] got_q[$];
    int         got_cyc[$];
    logic [7:0] exp_q[$];
    int         busy_drop;

    typedef struct {
        logic [RW-1:0] r;
        logic          s;
        logic          o;
        int            mode;   // 0: txready high, 1: toggling, 2: random
        int            s2;     // cycle of a second strobe, -1 for none
        logic [RW-1:0] r2;
        int            lat;    // required first txclk cycle, -1 to skip
        logic [47:0]   exp;
        int            len;
    } vec_t;

    always #5 clk = ~clk;

    result_uart_tx dut (
        .clk          (clk),
        .nrst         (nrst),
        .result       (result),
        .sign         (sign),
        .o_flag       (o_flag),
        .result_ready (result_ready),
        .txready      (txready),
        .txdata       (txdata),
        .txclk        (txclk),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic tx_pat(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return cyc[0];
        return 1'($urandom % 2);
    endfunction

    // Reference: the line is the decimal text of the magnitude, as a formatter would print it.
    task automatic model_line(input logic [RW-1:0] r, input logic s, input logic o);
        string txt;
        if (o) begin
            txt = "OVF";
        end else begin
            txt = $sformatf("%0d", r);
            if (s && r != 0) exp_q.push_back(8'h2D);
        end
        for (int i = 0; i < txt.len(); i++) exp_q.push_back(txt[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic run_txn(input logic [RW-1:0] r, input logic s, input logic o, input int mode,
                           input int s2, input logic [RW-1:0] r2);
        int         cyc;
        int         tail;
        logic [7:0] stall_q[$];
        got_q.delete();
        got_cyc.delete();
        busy_drop = -1;
        @(posedge clk); #1;
        result = r; sign = s; o_flag = o; result_ready = 1'b1;
        txready = tx_pat(mode, 0);
        cyc = 0;
        forever begin
            @(negedge clk);
            if (cyc == s2) check("busy_at_strobe2", 48'(busy), 48'd1);
            if (txclk) begin
                check("txclk_needs_txready", 48'(txready), 48'd1);
                if (got_q.size() > 0 && s2 < 0) begin
                    foreach (stall_q[i]) check("stall_hold", 48'(stall_q[i]), 48'(txdata));
                end
                got_q.push_back(txdata);
                got_cyc.push_back(cyc);
                stall_q.delete();
            end else if (got_q.size() > 0 && busy) begin
                stall_q.push_back(txdata);
            end
            if (cyc > 0 && !busy) begin
                busy_drop = cyc;
                break;
            end
            if (cyc > MaxCyc) begin
                check("timeout", 48'(cyc), 48'(MaxCyc));
                break;
            end
            @(posedge clk); #1;
            result_ready = 1'b0;
            cyc++;
            if (cyc == s2) begin
                result = r2; sign = 1'b0; o_flag = 1'b0; result_ready = 1'b1;
            end
            txready = tx_pat(mode, cyc);
        end
        tail = 0;
        txready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (txclk || busy) tail++;
        end
        check("idle_after_line", 48'(tail), 48'd0);
    endtask

    task automatic compare_line(input string tag, input int lat, input logic single);
        int n;
        n = got_q.size();
        check({tag, "_len"}, 48'(n), 48'(exp_q.size()));
        for (int k = 0; k < n && k < exp_q.size(); k++) begin
            check($sformatf("%s_byte%0d", tag, k), 48'(got_q[k]), 48'(exp_q[k]));
        end
        if (n > 0) begin
            check({tag, "_busy_drop"}, 48'(busy_drop), 48'(got_cyc[n-1] + 1));
            if (lat >= 0) begin
                check({tag, "_latency"}, 48'(got_cyc[0]), 48'(lat));
                if (single) check({tag, "_consecutive"}, 48'(got_cyc[n-1] - got_cyc[0]), 48'(n - 1));
            end
        end
    endtask

    initial begin
        vec_t       tbl[10];
        logic [47:0] e;
        int          cnt;
        int          seen;

        tbl[0] = '{9'd123, 1'b0, 1'b0, 0, -1, 9'd0, 11, 48'h0000_3132_330D_0A00 >> 8, 5};
        tbl[1] = '{9'd7,   1'b1, 1'b0, 0, -1, 9'd0, 11, 48'h0000_2D37_0D0A, 4};
        tbl[2] = '{9'd0,   1'b1, 1'b0, 0, -1, 9'd0, 11, 48'h0000_0030_0D0A, 3};
        tbl[3] = '{9'h1FF, 1'b1, 1'b1, 0, -1, 9'd0, 2,  48'h004F_5646_0D0A, 5};
        tbl[4] = '{9'd511, 1'b0, 1'b0, 0, -1, 9'd0, 11, 48'h0035_3131_0D0A, 5};
        tbl[5] = '{9'd40,  1'b0, 1'b0, 0, -1, 9'd0, 11, 48'h0000_3430_0D0A, 4};
        tbl[6] = '{9'd105, 1'b0, 1'b0, 0, -1, 9'd0, 11, 48'h0031_3035_0D0A, 5};
        tbl[7] = '{9'd58,  1'b0, 1'b0, 1, -1, 9'd0, -1, 48'h0000_3538_0D0A, 4};
`ifdef RESULT_UART_TX_PENDING_EN
        tbl[8] = '{9'd1,   1'b0, 1'b0, 0, 12, 9'd2, 11, 48'h310D_0A32_0D0A, 6};
        tbl[9] = '{9'd7,   1'b0, 1'b0, 0, 13, 9'd3, 11, 48'h370D_0A33_0D0A, 6};
`else
        tbl[8] = '{9'd1,   1'b0, 1'b0, 0, 12, 9'd2, 11, 48'h0000_310D_0A, 3};
        tbl[9] = '{9'd7,   1'b0, 1'b0, 0, 13, 9'd3, 11, 48'h0000_370D_0A, 3};
`endif

        // Reset values, with txready high so txclk cannot be masked by it.
        nrst = 1'b0;
        txready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_txdata", 48'(txdata), 48'h00);
        check("reset_txclk", 48'(txclk), 48'd0);
        check("reset_busy", 48'(busy), 48'd0);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_txclk", 48'(txclk), 48'd0);

        foreach (tbl[v]) begin
            exp_q.delete();
            e = tbl[v].exp;
            for (int k = 0; k < tbl[v].len; k++) exp_q.push_back(e[8*(tbl[v].len-1-k) +: 8]);
            run_txn(tbl[v].r, tbl[v].s, tbl[v].o, tbl[v].mode, tbl[v].s2, tbl[v].r2);
            compare_line($sformatf("vec%0d", v), tbl[v].lat, tbl[v].s2 < 0);
        end

        // Reset after the second byte: outputs drop at once and nothing follows release.
        @(posedge clk); #1;
        result = 9'd123; sign = 1'b0; o_flag = 1'b0; result_ready = 1'b1; txready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        seen = 0;
        for (int c = 0; c < 40 && seen < 2; c++) begin
            @(negedge clk);
            if (txclk) seen++;
        end
        check("rst_two_bytes_seen", 48'(seen), 48'd2);
        #2 nrst = 1'b0;
        #1;
        check("rst_txclk", 48'(txclk), 48'd0);
        check("rst_busy", 48'(busy), 48'd0);
        check("rst_txdata", 48'(txdata), 48'h00);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (txclk || busy) cnt++;
        end
        check("rst_no_more_bytes", 48'(cnt), 48'd0);

        // Randomized results against the formatting model.
        for (int t = 0; t < 25; t++) begin
            logic [RW-1:0] r;
            logic          s;
            logic          o;
            int            mode;
            r    = RW'($urandom_range(0, 511));
            s    = 1'($urandom % 2);
            o    = ($urandom % 6) == 0;
            mode = int'($urandom % 3);
            exp_q.delete();
            model_line(r, s, o);
            run_txn(r, s, o, mode, -1, '0);
            compare_line($sformatf("rnd%0d_r%0d_s%0d_o%0d", t, r, s, o),
                         (mode == 0) ? (o ? 2 : RW + 2) : -1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
- Sits at the output end of the calculator datapath, the reverse direction of the keypad/opcode encoders.
- On each `result_ready` pulse it captures the ALU result, sign and overflow flag.
- It converts the magnitude to decimal with a sequential binary-to-BCD converter.
- It streams the result as an ASCII line over the byte-wide UART transmit interface (`txdata` / `txclk` / `txready`).

Parameters:
- RESULT_W, 9: width of the unsigned result magnitude.
- DIGITS, 3: number of decimal digits. Must satisfy 10^DIGITS > 2^RESULT_W - 1.

Ports:
- clk  input  1  system clock. One clock domain. All state changes on rising edge.
- nrst  input  1  reset. Asynchronous, active-low.
- result  input  RESULT_W  unsigned magnitude from the ALU.
- sign  input  1  1 = result is negative.
- o_flag  input  1  1 = ALU overflow.
- result_ready  input  1  one-cycle strobe: result/sign/o_flag are valid this cycle.
- txready  input  1  UART can accept a byte this cycle.
- txdata  output  8  ASCII byte being offered.
- txclk  output  1  byte strobe. A byte transfers on any cycle with txclk=1 (txclk implies txready=1).
- busy  output  1  high from capture until the last byte is accepted.

Behaviour:
- Reset values: state IDLE, txdata=8'h00, txclk=0, busy=0, all capture/BCD/index registers 0. Asserting nrst mid-conversion or mid-send aborts the line immediately; no partial bytes follow after release.
- FSM states: IDLE, CONVERT, BUILD, SEND.
- IDLE:
  - result_ready=1 captures result, sign and o_flag.
  - busy=1 from the next cycle.
  - Next state: BUILD if o_flag=1, else CONVERT.
- CONVERT:
  - Iterative double-dabble: exactly RESULT_W cycles, one shift per cycle, add-3 to each BCD nibble >=5 before the shift.
  - Then go to BUILD.
- BUILD (1 cycle): loads the line buffer (up to 6 bytes) and a length count. Line content:
  - Overflow: "OVF\r\n" = 4F 56 46 0D 0A. result and sign are ignored.
  - Otherwise: optional '-' (2D) only when sign=1 and magnitude!=0, then the decimal digits with leading zeros suppressed (magnitude 0 prints a single '0'), then 0D 0A. Inner zeros are kept.
- SEND:
  - txdata is registered and holds the current byte stable while waiting.
  - txclk = (state==SEND) && txready, combinational.
  - Each cycle with txclk=1 advances the index; the next byte appears the following cycle.
  - After the LF is accepted: go to IDLE, busy=0 on the next cycle.
- Latency: result_ready at cycle 0 means the first txclk can occur at cycle RESULT_W+2 (11 with defaults) if txready=1. With txready held high, bytes go out on consecutive cycles.
- result_ready while busy=1: dropped (see optional feature).
- result_ready in the same cycle the final byte is accepted: dropped. busy is still 1 in that cycle.
- Out-of-range input (RESULT_W bits, but the magnitude is printed as-is): up to DIGITS digits are always sufficient given the parameter constraint.

Optional Feature:
- Macro: RESULT_UART_TX_PENDING_EN.
- Defined: adds a one-deep pending register, loaded by result_ready while busy (a newer strobe overwrites older pending data). On return to IDLE, a valid pending entry is taken as a new capture on the next cycle, without needing a strobe. busy stays high continuously between the two lines.
- Undefined: strobes while busy are ignored, with no extra state.

Decomposition:
- Package result_tx_pkg holds:
  - state_t enum {IDLE, CONVERT, BUILD, SEND}
  - ASCII constants: ASCII_0=8'h30, ASCII_MINUS=8'h2D, ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_O=8'h4F, ASCII_V=8'h56, ASCII_F=8'h46
  - MAX_LINE=6
- Sub-module bin2bcd_seq:
  - Ports: start, bin in, done, bcd out, parameterised by RESULT_W/DIGITS.
  - Contains the iterative double-dabble.
  - The top FSM owns BUILD/SEND and the line buffer.

Test Plan:
- result=123, sign=0, txready=1 held: first txclk at cycle 11; bytes 31 32 33 0D 0A on 5 consecutive txclk; busy drops the cycle after LF.
- sign=1, result=7 gives 2D 37 0D 0A. sign=1, result=0 gives 30 0D 0A (no minus).
- o_flag=1, result=9'h1FF, sign=1 gives 4F 56 46 0D 0A; first txclk at cycle 2.
- Boundary and zero suppression: result=511 gives 35 31 31 0D 0A; result=40 gives 34 30 0D 0A; result=0 gives 30 0D 0A; result=105 gives 31 30 35 0D 0A.
- Flow control: txready toggling 1/0 each cycle during result=58:
  - txclk only on txready=1 cycles.
  - Order 35 38 0D 0A.
  - txdata unchanged across stall cycles.
- Overlap and reset:
  - result=1 then result_ready(result=2) during SEND: only "1\r\n" without the macro; "1\r\n2\r\n" with RESULT_UART_TX_PENDING_EN.
  - nrst low after the 2nd byte: txclk=0, busy=0 immediately; no further bytes after release.
